// File: rtl/shift_rotate_reg_if.sv
// Host-side bus for the shift/rotate register: load/start controls in, register state out.
interface shift_rotate_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             carry_out;

    // Host side drives requests and observes the register
    modport master (
        output load, load_data, start, mode, amount,
        input  q, busy, done, carry_out
    );

    // Register side consumes requests and reports state
    modport slave (
        input  load, load_data, start, mode, amount,
        output q, busy, done, carry_out
    );
endinterface

// File: rtl/shift_rotate_reg.sv
// WIDTH-bit register with parallel load and a multi-cycle shift/rotate
// operation that moves the contents one bit position per clock.
module shift_rotate_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    shift_rotate_reg_if.slave  bus
);
    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_LSL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_FIN   = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_count;

    logic [WIDTH-1:0] w_step_q;
    logic             w_step_carry;

    // One single-bit step of the latched mode applied to the current contents
    always_comb begin
        w_step_q     = r_q;
        w_step_carry = r_carry;
        case (r_mode)
            MODE_ROR: begin
                w_step_q     = {r_q[0], r_q[WIDTH-1:1]};
                w_step_carry = r_q[0];
            end
            MODE_ROL: begin
                w_step_q     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_step_carry = r_q[WIDTH-1];
            end
            MODE_ASR: begin
                w_step_q     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_step_carry = r_q[0];
            end
            MODE_LSL: begin
                w_step_q     = {r_q[WIDTH-2:0], 1'b0};
                w_step_carry = r_q[WIDTH-1];
            end
        endcase
    end

    // Control FSM and datapath registers; busy/done are produced one edge
    // ahead so they line up with the state they describe
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mode  <= MODE_ROR;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.load) begin
                        r_q     <= bus.load_data;
                        r_carry <= 1'b0;
                    end else if (bus.start) begin
                        r_mode  <= bus.mode;
                        r_count <= bus.amount;
                        if (bus.amount == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_q     <= w_step_q;
                    r_carry <= w_step_carry;
                    r_count <= r_count - AMT_W'(1);
                    if (r_count == AMT_W'(1)) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    assign bus.q         = r_q;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.carry_out = r_carry;
endmodule

// File: tb/tb_shift_rotate_reg.sv
// Bench for shift_rotate_reg: directed vector table, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_shift_rotate_reg;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    shift_rotate_reg_if #(.WIDTH(8),  .AMT_W(3)) ifa ();
    shift_rotate_reg_if #(.WIDTH(12), .AMT_W(4)) ifb ();

    shift_rotate_reg #(.WIDTH(8),  .AMT_W(3)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    shift_rotate_reg #(.WIDTH(12), .AMT_W(4)) dut_b (.clock(clock), .reset(reset), .bus(ifb));

    int n_tests = 0;
    int n_fail  = 0;

    int          width [2] = '{8, 12};
    int          amax  [2] = '{7, 15};
    logic [31:0] mq    [2];
    logic        mc    [2];

    typedef struct {
        logic [7:0] init;
        logic [1:0] mode;
        int         amt;
        logic [7:0] exp_q;
        logic       exp_c;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic ld, input logic [31:0] d,
                          input logic st, input logic [1:0] m, input logic [31:0] a);
        if (sel == 0) begin
            ifa.load = ld; ifa.load_data = d[7:0]; ifa.start = st;
            ifa.mode = m;  ifa.amount = a[2:0];
        end else begin
            ifb.load = ld; ifb.load_data = d[11:0]; ifb.start = st;
            ifb.mode = m;  ifb.amount = a[3:0];
        end
    endtask

    task automatic rd(input int sel, output logic [31:0] q, output logic b,
                      output logic d, output logic c);
        if (sel == 0) begin
            q = 32'(ifa.q); b = ifa.busy; d = ifa.done; c = ifa.carry_out;
        end else begin
            q = 32'(ifb.q); b = ifb.busy; d = ifb.done; c = ifb.carry_out;
        end
    endtask

    // Result of 'a' single-bit steps, computed in one go from shift/rotate arithmetic
    function automatic void model(input int w, input logic [31:0] q, input logic c,
                                  input logic [1:0] m, input int a,
                                  output logic [31:0] nq, output logic nc);
        logic [31:0] mask;
        int          k;
        logic        sign;
        mask = (32'd1 << w) - 32'd1;
        nq   = q;
        nc   = c;
        if (a != 0) begin
            case (m)
                2'b00: begin
                    k  = a % w;
                    nq = ((q >> k) | (q << (w - k))) & mask;
                    nc = nq[w-1];
                end
                2'b01: begin
                    k  = a % w;
                    nq = ((q << k) | (q >> (w - k))) & mask;
                    nc = nq[0];
                end
                2'b10: begin
                    sign = q[w-1];
                    if (a >= w) begin
                        nq = sign ? mask : 32'd0;
                        nc = sign;
                    end else begin
                        nq = (q >> a) | (sign ? (mask & ~(mask >> a)) : 32'd0);
                        nc = q[a-1];
                    end
                end
                default: begin
                    if (a > w) begin
                        nq = 32'd0;
                        nc = 1'b0;
                    end else begin
                        nq = (q << a) & mask;
                        nc = q[w-a];
                    end
                end
            endcase
        end
    endfunction

    task automatic do_load(input int sel, input logic [31:0] d);
        set_in(sel, 1'b1, d, 1'b0, 2'b00, 32'd0);
        tick();
        set_in(sel, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
    endtask

    // Start an operation and count cycles until done; optionally disturb inputs mid-run
    task automatic run_op(input int sel, input logic [1:0] m, input int a, input int disturb_at,
                          output int lat, output int bcnt);
        logic [31:0] q;
        logic        b, d, c;
        set_in(sel, 1'b0, 32'd0, 1'b1, m, 32'(a));
        tick();
        set_in(sel, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        lat  = 1;
        bcnt = 0;
        rd(sel, q, b, d, c);
        while (!d && lat < 40) begin
            if (b) bcnt++;
            if (lat == disturb_at)
                set_in(sel, 1'b1, 32'hFFFF_FFFF, 1'b1, ~m, 32'd1);
            else
                set_in(sel, 1'b0, 32'd0, 1'b0, ~m, 32'd0);
            tick();
            lat++;
            rd(sel, q, b, d, c);
        end
        set_in(sel, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        chk("done_seen", 32'(d), 32'd1);
        chk("busy_low_in_done", 32'(b), 32'd0);
    endtask

    task automatic op_and_check(input string tag, input int sel, input logic [1:0] m, input int a,
                                input int disturb_at, input bit fin_poke,
                                input logic [31:0] eq, input logic ec);
        int          lat, bcnt;
        logic [31:0] q;
        logic        b, d, c;
        run_op(sel, m, a, disturb_at, lat, bcnt);
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(a + 1));
        chk($sformatf("%s.busy_cycles", tag), 32'(bcnt), 32'(a));
        rd(sel, q, b, d, c);
        chk($sformatf("%s.q", tag), q, eq);
        chk($sformatf("%s.carry", tag), 32'(c), 32'(ec));
        if (fin_poke) set_in(sel, 1'b1, 32'd0, 1'b1, 2'b11, 32'd3);
        tick();
        set_in(sel, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        rd(sel, q, b, d, c);
        chk($sformatf("%s.done_width", tag), 32'(d), 32'd0);
        chk($sformatf("%s.q_hold", tag), q, eq);
        chk($sformatf("%s.idle_busy", tag), 32'(b), 32'd0);
    endtask

    initial begin
        logic [31:0] q, nq, rdata;
        logic        b, d, c, nc;
        int          sel, a, seen;
        logic [1:0]  m;

        vecs[0] = '{8'h81, 2'b00, 1, 8'hC0, 1'b1};
        vecs[1] = '{8'h81, 2'b01, 3, 8'h0C, 1'b0};
        vecs[2] = '{8'h90, 2'b10, 7, 8'hFF, 1'b0};
        vecs[3] = '{8'h90, 2'b11, 5, 8'h00, 1'b0};
        vecs[4] = '{8'h3C, 2'b00, 0, 8'h3C, 1'b0};
        vecs[5] = '{8'hA5, 2'b01, 7, 8'hD2, 1'b0};
        vecs[6] = '{8'h5A, 2'b10, 2, 8'h16, 1'b1};
        vecs[7] = '{8'h01, 2'b11, 7, 8'h80, 1'b0};
        vecs[8] = '{8'h80, 2'b01, 1, 8'h01, 1'b1};
        vecs[9] = '{8'hF0, 2'b00, 4, 8'h0F, 1'b0};

        // Reset, with a load request that reset must override
        set_in(0, 1'b1, 32'hAA, 1'b0, 2'b00, 32'd0);
        set_in(1, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        repeat (3) tick();
        set_in(0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rd(s, q, b, d, c);
            chk($sformatf("reset.q%0d", s), q, 32'd0);
            chk($sformatf("reset.busy%0d", s), 32'(b), 32'd0);
            chk($sformatf("reset.done%0d", s), 32'(d), 32'd0);
            chk($sformatf("reset.carry%0d", s), 32'(c), 32'd0);
        end

        // Plain load
        do_load(0, 32'hA5);
        rd(0, q, b, d, c);
        chk("load.q", q, 32'hA5);
        chk("load.carry", 32'(c), 32'd0);
        chk("load.busy", 32'(b), 32'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_load(0, 32'(vecs[i].init));
            rd(0, q, b, d, c);
            chk($sformatf("v%0d.load_q", i), q, 32'(vecs[i].init));
            chk($sformatf("v%0d.load_carry", i), 32'(c), 32'd0);
            op_and_check($sformatf("v%0d", i), 0, vecs[i].mode, vecs[i].amt, -1, 1'b0,
                         32'(vecs[i].exp_q), vecs[i].exp_c);
        end

        // Load/start/mode changes during SHIFT and load/start in FIN are ignored
        do_load(0, 32'hB3);
        op_and_check("stable", 0, 2'b01, 7, 2, 1'b1, 32'hD9, 1'b1);

        // Load and start in the same idle cycle: load only
        set_in(0, 1'b1, 32'h5A, 1'b1, 2'b00, 32'd3);
        tick();
        set_in(0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        rd(0, q, b, d, c);
        chk("ldst.q", q, 32'h5A);
        chk("ldst.busy", 32'(b), 32'd0);
        tick();
        rd(0, q, b, d, c);
        chk("ldst.busy2", 32'(b), 32'd0);
        chk("ldst.done2", 32'(d), 32'd0);
        chk("ldst.q2", q, 32'h5A);

        // Reset in the middle of a 6-step rotate
        do_load(0, 32'h6D);
        set_in(0, 1'b0, 32'd0, 1'b1, 2'b00, 32'd6);
        tick();
        set_in(0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0);
        tick();
        tick();
        rd(0, q, b, d, c);
        chk("abort.busy_before", 32'(b), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(0, q, b, d, c);
        chk("abort.q", q, 32'd0);
        chk("abort.busy", 32'(b), 32'd0);
        chk("abort.carry", 32'(c), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            rd(0, q, b, d, c);
            if (d || b) seen++;
            tick();
        end
        chk("abort.no_done", 32'(seen), 32'd0);

        // Wide instance: amount beyond width wraps
        do_load(1, 32'h801);
        op_and_check("w12", 1, 2'b00, 13, -1, 1'b0, 32'hC00, 1'b1);
        mq[1] = 32'hC00;
        mc[1] = 1'b1;
        mq[0] = 32'd0;
        mc[0] = 1'b0;

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            sel = (i < 2) ? i : int'($urandom_range(0, 1));
            if (i < 2 || $urandom_range(0, 3) != 0) begin
                rdata = $urandom & ((32'd1 << width[sel]) - 32'd1);
                do_load(sel, rdata);
                mq[sel] = rdata;
                mc[sel] = 1'b0;
            end
            m = 2'($urandom_range(0, 3));
            a = int'($urandom_range(0, amax[sel]));
            model(width[sel], mq[sel], mc[sel], m, a, nq, nc);
            op_and_check($sformatf("rnd%0d", i), sel, m, a, -1, 1'b0, nq, nc);
            mq[sel] = nq;
            mc[sel] = nc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
